conv_window_addr_gen: RTL and testbench

CONV_WINDOW_ADDR_GEN -- requirements
Module: conv_window_addr_gen

---
 rtl/cnn_addr_pkg.sv | 15 +
 rtl/stride_wrap_counter.sv | 38 +++
 rtl/conv_window_addr_gen.sv | 161 ++++++++++++++++
 tb/tb_conv_window_addr_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_addr_pkg.sv
// Shared definitions for the CNN address-generation blocks: FSM state
// encoding and the default image/kernel geometry.
package cnn_addr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;
    localparam int DEF_K     = 3;

endpackage

// File: rtl/stride_wrap_counter.sv
// Counter that advances by STEP on inc and wraps from LIMIT back to 0.
// wrap flags the increment that causes the wrap, so it can chain into the
// next counter of a nested scan.
module stride_wrap_counter #(
    parameter int CNT_W = 10,
    parameter int LIMIT = 25,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_limit,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] STEP_V  = CNT_W'(STEP);

    logic [CNT_W-1:0] count_reg;

    assign count    = count_reg;
    assign at_limit = (count_reg == LIMIT_V);
    assign wrap     = inc & at_limit;

    // Count register: clear has priority, otherwise step or wrap on inc.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= at_limit ? '0 : count_reg + STEP_V;
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// Convolution window scanner: walks the top-left corner of a KxK window
// over every channel of an IMG_W x IMG_H image with a given stride and
// emits the flat memory address of each window under valid/ready.
// Addresses are built from running bases with adds only.
module conv_window_addr_gen
    import cnn_addr_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int STRIDE = 1,
    parameter int N_CH   = 1,
    parameter int CNT_W  = 10,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              ready,
    output logic              valid,
    output logic [CNT_W-1:0]  row,
    output logic [CNT_W-1:0]  col,
    output logic [CNT_W-1:0]  ch,
    output logic [ADDR_W-1:0] addr,
    output logic              last,
    output logic              busy,
    output logic              done
);

    localparam int OUT_W = (IMG_W - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - K) / STRIDE + 1;
    localparam longint TOTAL_WORDS = longint'(N_CH) * longint'(IMG_W) * longint'(IMG_H);

    localparam logic [ADDR_W-1:0] COL_STEP = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(STRIDE * IMG_W);
    localparam logic [ADDR_W-1:0] CH_STEP  = ADDR_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0]  CH_LAST  = CNT_W'(N_CH - 1);

    // Reject geometries the scan cannot represent.
    if (K > IMG_W) begin : g_bad_k_w
        $error("conv_window_addr_gen: K exceeds IMG_W");
    end
    if (K > IMG_H) begin : g_bad_k_h
        $error("conv_window_addr_gen: K exceeds IMG_H");
    end
    if (TOTAL_WORDS > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
        $error("conv_window_addr_gen: image does not fit in ADDR_W");
    end

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  ch_reg;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W-1:0] row_base_reg, row_base_next;
    logic [ADDR_W-1:0] ch_base_reg, ch_base_next;

    logic run, xfer, run_abort, last_w, ctr_clr;
    logic col_at_max, col_wrap, row_at_max, row_wrap;

    assign run       = (state_reg == ST_RUN);
    assign run_abort = run & abort;
    // Abort wins over a transfer in the same cycle.
    assign xfer      = run & ready & ~abort;
    assign last_w    = run & col_at_max & row_at_max & (ch_reg == CH_LAST);
    assign ctr_clr   = run_abort | (xfer & last_w);

    stride_wrap_counter #(
        .CNT_W (CNT_W),
        .LIMIT ((OUT_W - 1) * STRIDE),
        .STEP  (STRIDE)
    ) u_col_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .inc      (xfer),
        .count    (col),
        .at_limit (col_at_max),
        .wrap     (col_wrap)
    );

    stride_wrap_counter #(
        .CNT_W (CNT_W),
        .LIMIT ((OUT_H - 1) * STRIDE),
        .STEP  (STRIDE)
    ) u_row_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (ctr_clr),
        .inc      (col_wrap),
        .count    (row),
        .at_limit (row_at_max),
        .wrap     (row_wrap)
    );

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start && !abort) state_next = ST_RUN;
            ST_RUN: begin
                if (abort)               state_next = ST_IDLE;
                else if (xfer && last_w) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Address datapath: step within a row, jump to the next row base on
    // col wrap, and to the next channel base on row wrap.
    always_comb begin
        addr_next     = addr_reg;
        row_base_next = row_base_reg;
        ch_base_next  = ch_base_reg;
        if (ctr_clr) begin
            addr_next     = '0;
            row_base_next = '0;
            ch_base_next  = '0;
        end else if (xfer) begin
            if (!col_at_max) begin
                addr_next = addr_reg + COL_STEP;
            end else if (!row_at_max) begin
                row_base_next = row_base_reg + ROW_STEP;
                addr_next     = row_base_reg + ROW_STEP;
            end else begin
                ch_base_next  = ch_base_reg + CH_STEP;
                row_base_next = ch_base_reg + CH_STEP;
                addr_next     = ch_base_reg + CH_STEP;
            end
        end
    end

    // State, channel counter and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ch_reg       <= '0;
            addr_reg     <= '0;
            row_base_reg <= '0;
            ch_base_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            row_base_reg <= row_base_next;
            ch_base_reg  <= ch_base_next;
            if (ctr_clr) begin
                ch_reg <= '0;
            end else if (row_wrap) begin
                ch_reg <= ch_reg + 1'b1;
            end
        end
    end

    assign valid = run;
    assign ch    = ch_reg;
    assign addr  = addr_reg;
    assign last  = last_w;
    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// Bench for conv_window_addr_gen: default geometry instance plus an
// 8x8 / stride 2 / two-channel instance, checked against a scoreboard of
// expected windows computed with plain multiplies.
module tb_conv_window_addr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-geometry DUT
    logic       d_rst, d_start, d_abort, d_ready;
    logic       d_valid, d_last, d_busy, d_done;
    logic [9:0] d_row, d_col, d_ch, d_addr;

    // 8x8, K=3, stride 2, two channels
    logic       s_rst, s_start, s_abort, s_ready;
    logic       s_valid, s_last, s_busy, s_done;
    logic [9:0] s_row, s_col, s_ch, s_addr;

    conv_window_addr_gen dut_def (
        .clk(clk), .rst(d_rst), .start(d_start), .abort(d_abort), .ready(d_ready),
        .valid(d_valid), .row(d_row), .col(d_col), .ch(d_ch), .addr(d_addr),
        .last(d_last), .busy(d_busy), .done(d_done)
    );

    conv_window_addr_gen #(
        .IMG_W(8), .IMG_H(8), .K(3), .STRIDE(2), .N_CH(2), .CNT_W(10), .ADDR_W(10)
    ) dut_s2 (
        .clk(clk), .rst(s_rst), .start(s_start), .abort(s_abort), .ready(s_ready),
        .valid(s_valid), .row(s_row), .col(s_col), .ch(s_ch), .addr(s_addr),
        .last(s_last), .busy(s_busy), .done(s_done)
    );

    typedef struct {
        int row;
        int col;
        int ch;
        int addr;
        bit last;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Fill the scoreboard with the full expected scan for one geometry.
    task automatic push_expected(input int out_w, input int out_h, input int stride,
                                 input int nch, input int img_w, input int img_h);
        exp_t e_item;
        sb_q.delete();
        for (int c = 0; c < nch; c++)
            for (int r = 0; r < out_h; r++)
                for (int x = 0; x < out_w; x++) begin
                    e_item.row  = r * stride;
                    e_item.col  = x * stride;
                    e_item.ch   = c;
                    e_item.addr = c * img_w * img_h + r * stride * img_w + x * stride;
                    e_item.last = (c == nch - 1) && (r == out_h - 1) && (x == out_w - 1);
                    sb_q.push_back(e_item);
                end
    endtask

    task automatic test_reset();
        checks++;
        if ({d_valid, d_last, d_busy, d_done, d_row, d_col, d_ch, d_addr} !== 44'd0) begin
            errors++;
            $display("FAIL reset_def: v=%b l=%b b=%b d=%b row=%0d col=%0d ch=%0d addr=%0d, all required 0",
                     d_valid, d_last, d_busy, d_done, d_row, d_col, d_ch, d_addr);
        end
        checks++;
        if ({s_valid, s_last, s_busy, s_done, s_row, s_col, s_ch, s_addr} !== 44'd0) begin
            errors++;
            $display("FAIL reset_s2: v=%b l=%b b=%b d=%b row=%0d col=%0d ch=%0d addr=%0d, all required 0",
                     s_valid, s_last, s_busy, s_done, s_row, s_col, s_ch, s_addr);
        end
        $display("reset: outputs checked on both instances");
    endtask

    // Full default scan; when stall_at >= 0 ready drops for 5 cycles there.
    task automatic test_full_scan(input int stall_at);
        exp_t e_item;
        int n = 0, cyc = 0, stall_cnt = 0;
        push_expected(26, 26, 1, 1, 28, 28);
        d_ready = 1'b1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        while (n < 676 && cyc < 5000) begin
            cyc++;
            checks++;
            if (!d_valid || d_done) begin
                errors++;
                $display("FAIL scan_valid: valid=%b done=%b at transfer %0d, required valid=1 done=0",
                         d_valid, d_done, n);
            end else begin
                e_item = sb_q[0];
                checks++;
                if (d_row !== 10'(e_item.row) || d_col !== 10'(e_item.col) || d_ch !== 10'(e_item.ch) ||
                    d_addr !== 10'(e_item.addr) || d_last !== e_item.last) begin
                    errors++;
                    $display("FAIL scan_window: n=%0d got row=%0d col=%0d ch=%0d addr=%0d last=%b, required %0d %0d %0d %0d %b",
                             n, d_row, d_col, d_ch, d_addr, d_last,
                             e_item.row, e_item.col, e_item.ch, e_item.addr, e_item.last);
                end
                if (n == 26) begin
                    checks++;
                    if (d_addr !== 10'd28) begin
                        errors++;
                        $display("FAIL row_jump: addr=%0d, required 28", d_addr);
                    end
                end
                if (n == 675) begin
                    checks++;
                    if (d_addr !== 10'd725 || d_last !== 1'b1) begin
                        errors++;
                        $display("FAIL final_window: addr=%0d last=%b, required 725 1", d_addr, d_last);
                    end
                end
                if (n == stall_at && stall_cnt < 5) begin
                    d_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    d_ready = 1'b1;
                    void'(sb_q.pop_front());
                    n++;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (n != 676 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL transfer_count: got %0d (left %0d), required 676", n, sb_q.size());
        end
        checks++;
        if (d_done !== 1'b1 || d_valid !== 1'b0 || d_busy !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b valid=%b busy=%b, required 1 0 1", d_done, d_valid, d_busy);
        end
        @(negedge clk);
        checks++;
        if (d_done !== 1'b0 || d_busy !== 1'b0 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: done=%b busy=%b valid=%b, required 0 0 0", d_done, d_busy, d_valid);
        end
        $display("full_scan(stall_at=%0d): %0d transfers, %0d stall cycles", stall_at, n, stall_cnt);
    endtask

    task automatic test_stride2();
        exp_t e_item;
        int n = 0, cyc = 0;
        push_expected(3, 3, 2, 2, 8, 8);
        s_ready = 1'b1;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        while (n < 18 && cyc < 200) begin
            cyc++;
            e_item = sb_q[0];
            checks++;
            if (!s_valid || s_row !== 10'(e_item.row) || s_col !== 10'(e_item.col) ||
                s_ch !== 10'(e_item.ch) || s_addr !== 10'(e_item.addr) || s_last !== e_item.last) begin
                errors++;
                $display("FAIL s2_window: n=%0d got v=%b row=%0d col=%0d ch=%0d addr=%0d last=%b, required 1 %0d %0d %0d %0d %b",
                         n, s_valid, s_row, s_col, s_ch, s_addr, s_last,
                         e_item.row, e_item.col, e_item.ch, e_item.addr, e_item.last);
            end
            if (n == 9) begin
                checks++;
                if (s_addr !== 10'd64 || s_ch !== 10'd1) begin
                    errors++;
                    $display("FAIL s2_tenth: addr=%0d ch=%0d, required 64 1", s_addr, s_ch);
                end
            end
            if (s_valid) begin
                void'(sb_q.pop_front());
                n++;
            end
            @(negedge clk);
        end
        checks++;
        if (n != 18 || s_done !== 1'b1 || s_valid !== 1'b0) begin
            errors++;
            $display("FAIL s2_end: transfers=%0d done=%b valid=%b, required 18 1 0", n, s_done, s_valid);
        end
        @(negedge clk);
        $display("stride2: %0d transfers", n);
    endtask

    task automatic test_rst_mid();
        int n = 0, cyc = 0;
        d_ready = 1'b1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        while (n < 100 && cyc < 500) begin
            cyc++;
            if (d_valid) n++;
            @(negedge clk);
        end
        d_rst = 1'b1;
        #1;
        checks++;
        if ({d_valid, d_last, d_busy, d_done, d_row, d_col, d_ch, d_addr} !== 44'd0) begin
            errors++;
            $display("FAIL rst_mid: v=%b l=%b b=%b d=%b row=%0d col=%0d ch=%0d addr=%0d, all required 0",
                     d_valid, d_last, d_busy, d_done, d_row, d_col, d_ch, d_addr);
        end
        @(negedge clk);
        d_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (d_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_idle_wait: busy=%b, required 0", d_busy);
        end
        d_ready = 1'b0;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        checks++;
        if (d_valid !== 1'b1 || d_addr !== 10'd0 || d_row !== 10'd0 || d_col !== 10'd0) begin
            errors++;
            $display("FAIL rst_restart: valid=%b addr=%0d row=%0d col=%0d, required 1 0 0 0",
                     d_valid, d_addr, d_row, d_col);
        end
        d_abort = 1'b1;
        @(negedge clk);
        d_abort = 1'b0;
        $display("rst_mid: reset after %0d transfers, restart checked", n);
    endtask

    task automatic test_start_abort();
        exp_t e_item;
        int n = 0, cyc = 0;
        push_expected(26, 26, 1, 1, 28, 28);
        d_ready = 1'b1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        while (n < 50 && cyc < 500) begin
            cyc++;
            e_item = sb_q[0];
            checks++;
            if (!d_valid || d_addr !== 10'(e_item.addr) || d_row !== 10'(e_item.row) ||
                d_col !== 10'(e_item.col)) begin
                errors++;
                $display("FAIL start_ignored: n=%0d valid=%b addr=%0d, required 1 %0d", n, d_valid, d_addr, e_item.addr);
            end
            d_start = (n == 5 || n == 20);
            void'(sb_q.pop_front());
            n++;
            @(negedge clk);
        end
        d_start = 1'b0;
        d_abort = 1'b1;
        @(negedge clk);
        d_abort = 1'b0;
        checks++;
        if ({d_valid, d_busy, d_done, d_row, d_col, d_ch, d_addr} !== 43'd0) begin
            errors++;
            $display("FAIL abort: v=%b b=%b d=%b row=%0d col=%0d ch=%0d addr=%0d, all required 0",
                     d_valid, d_busy, d_done, d_row, d_col, d_ch, d_addr);
        end
        @(negedge clk);
        checks++;
        if (d_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b, required 0", d_done);
        end
        d_start = 1'b1;
        d_abort = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        d_abort = 1'b0;
        checks++;
        if (d_busy !== 1'b0 || d_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_idle: busy=%b valid=%b, required 0 0", d_busy, d_valid);
        end
        $display("start_abort: aborted at transfer %0d", n);
    endtask

    initial begin
        d_rst = 1'b1; d_start = 1'b0; d_abort = 1'b0; d_ready = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        d_rst = 1'b0;
        s_rst = 1'b0;
        @(negedge clk);
        test_full_scan(-1);
        test_full_scan(10);
        test_stride2();
        test_rst_mid();
        test_start_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
